// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
// bit per clock, LSB-first (dir=1) or MSB-first (dir=0), chosen per word.
// frame_o marks valid bits and last_o marks the final bit of each word, so a
// downstream serial-in register needs no bit counter of its own. ready_o is
// raised on the last bit, so words can stream back-to-back with no gap.
module piso_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             dir_i,
  output logic             data_o,
  output logic             frame_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("piso_tx: WIDTH must be in 2..32");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             dir_q,   dir_d;

  logic on_last;
  logic accept;

  // The final bit of a word is on the line; the next word may be loaded now.
  assign on_last = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
  assign accept  = valid_i && ready_o;

  // State register: shift register, bit counter, latched bit order and FSM state.
  // NOTE: the shift register is small and sits in flops, so it takes the async
  // reset like every other register; a mid-word reset discards the word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic: load on handshake, otherwise shift or return to idle.
  always_comb begin
    // NOTE: hold-current defaults on every path keep this purely combinational.
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    if (accept) begin
      // Same load from IDLE and on the last bit of a running word.
      state_d = S_SHIFT;
      sreg_d  = data_i;
      cnt_d   = '0;
      dir_d   = dir_i;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Nothing loaded; wait for a handshake.
        end
        S_SHIFT: begin
          if (on_last) begin
            state_d = S_IDLE;
            sreg_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dir_q) begin
              sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end else begin
              sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output logic: every output is decoded from registered state only.
  always_comb begin
    ready_o = 1'b0;
    frame_o = 1'b0;
    busy_o  = 1'b0;
    last_o  = 1'b0;
    data_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
      end
      S_SHIFT: begin
        ready_o = on_last;
        frame_o = 1'b1;
        busy_o  = 1'b1;
        last_o  = on_last;
        data_o  = dir_q ? sreg_q[0] : sreg_q[WIDTH-1];
      end
      default: begin
        ready_o = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter that serialises WIDTH-bit words onto a single-bit line. It is the transmit-side counterpart of the serial shift-register receiver path. It accepts words on a valid/ready handshake and shifts each one out LSB-first or MSB-first, chosen per word. Framing strobes mark the valid bits and the final bit of each word, so a downstream serial-in register can capture frames without a separate bit counter.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- data_i  input  WIDTH  parallel word to transmit
- valid_i  input  1  data_i/dir_i hold a word to send
- ready_o  output  1  block can accept a word this cycle
- dir_i  input  1  bit order for the offered word: 1 = right shift (LSB first), 0 = left shift (MSB first)
- data_o  output  1  serial data bit
- frame_o  output  1  data_o carries a valid bit this cycle
- last_o  output  1  current bit is the final bit of the word
- busy_o  output  1  a word is being shifted out

## Operation
- FSM states:
  - IDLE: no word loaded.
  - SHIFT: a word is being shifted out.
- Internal state:
  - sreg[WIDTH-1:0]: shift register.
  - cnt: bit counter, $clog2(WIDTH) bits.
  - dir_q: latched bit order.
- Accept: a handshake occurs on a rising edge where valid_i && ready_o.
- ready_o = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1). It is combinational from state only and never depends on valid_i.
- On a handshake:
  - sreg <= data_i, dir_q <= dir_i, cnt <= 0, state <= SHIFT.
  - This applies both from IDLE and on the last bit of a running word (back-to-back).
- In SHIFT without a handshake:
  - If cnt < WIDTH-1: cnt increments. When dir_q=1, sreg <= {1'b0, sreg[WIDTH-1:1]}. When dir_q=0, sreg <= {sreg[WIDTH-2:0], 1'b0}.
  - If cnt == WIDTH-1 and there is no handshake: state <= IDLE and sreg <= 0.
- data_o = frame_o ? (dir_q ? sreg[0] : sreg[WIDTH-1]) : 1'b0.
- frame_o = busy_o = (state==SHIFT).
- last_o = (state==SHIFT && cnt==WIDTH-1).
- dir_i and data_i are ignored unless a handshake occurs. Changing them mid-word has no effect.
- valid_i held high while ready_o is low produces no accept and no state change. The word is taken at the next ready_o cycle.
- Reset (asserted at any time, including mid-word):
  - Immediately forces state=IDLE and sreg=0, cnt=0, dir_q=0.
  - The current word is discarded and is not resumed after release.

## Timing
- Reset values:
  - ready_o=1
  - data_o=0, frame_o=0, last_o=0, busy_o=0
- Latency: a word accepted at edge N drives its first bit during cycle N+1 (after edge N) and its last bit during cycle N+WIDTH.
- Throughput: one bit per clock. Back-to-back handshakes on each last_o cycle give continuous frame_o with zero idle cycles between words.
- A single word occupies exactly WIDTH cycles of frame_o=1. last_o is high for exactly 1 cycle per word.
- Without a back-to-back handshake, frame_o falls on the edge after last_o, and ready_o remains 1 in IDLE.
- All outputs are glitch-free functions of registered state. There is no combinational path from valid_i, data_i or dir_i to any output.
- Reset release: the first handshake is possible on the first rising edge with rst_n_i high.

## Test plan
- Reset, then idle with valid_i=0: ready_o=1, and data_o, frame_o, last_o, busy_o all stay 0 for 10 cycles.
- WIDTH=4, send 4'b1011 with dir_i=1: data_o sequence is 1,1,0,1 over 4 cycles starting the cycle after accept; last_o is high on the 4th bit only; the next cycle returns to IDLE.
- Send 4'b1011 with dir_i=0: data_o sequence is 1,0,1,1. Toggling dir_i mid-word leaves the sequence unchanged.
- Back-to-back 4'hA (dir 1), then 4'h5 (dir 0), with valid_i held high: the second accept happens on the last_o cycle; output is 0,1,0,1,0,1,0,1 with frame_o high for 8 consecutive cycles. ready_o is low during cycles 1-3 of each word.
- Assert rst_n_i low asynchronously after the 2nd bit of 4'hF: all outputs go to reset values without waiting for a clock edge. After release, a new word 4'h3 (dir 1) sends 1,1,0,0 correctly.
- WIDTH=8, send 8'h81 with dir_i=0: output is 1,0,0,0,0,0,0,1; cnt wraps correctly and last_o is high on bit 8.
